// File: rtl/fixed2float16_stream.sv
// fixed2float16_stream
//   Streaming converter from a fixed-point integer (signed or unsigned, with
//   FRAC_W fraction bits) to IEEE-754 binary16. Three register stages:
//     S1  sign / magnitude
//     S2  leading-one detect and normalise
//     S3  round-to-nearest-even, exponent adjust, saturate/flush, pack
//   Beats with cast_=0 travel the same pipeline untouched (low 16 bits of
//   in_data), so ordering and latency are identical for both kinds of beat.
//
// Ports
//   clk, reset              clock, asynchronous active-high reset
//   in_valid/in_ready       input handshake; in_ready = pipeline advance
//   in_data[IN_W-1:0]       fixed-point operand or raw fp16 bits
//   in_signed               in_data is two's complement
//   cast_                   1 = convert, 0 = pass through
//   out_valid/out_ready     output handshake
//   out_fl16[15:0]          binary16 result
//   out_ovf                 result saturated to infinity
//   out_unf                 nonzero input flushed to zero
module fixed2float16_stream #(
  parameter int IN_W   = 16,
  parameter int FRAC_W = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] in_data,
  input  logic            in_signed,
  input  logic            cast_,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [15:0]     out_fl16,
  output logic            out_ovf,
  output logic            out_unf
);

  // Bits kept below the leading one after normalisation, and the width of
  // that fraction padded with 11 zeros so mantissa, guard and sticky can
  // always be sliced even when IN_W is smaller than the 10-bit mantissa.
  localparam int FW = IN_W - 1;
  localparam int XW = FW + 11;

  logic advance;

  // S1 state
  logic            s1_valid_q, s1_valid_d;
  logic            s1_sign_q,  s1_sign_d;
  logic            s1_cast_q,  s1_cast_d;
  logic [IN_W-1:0] s1_mag_q,   s1_mag_d;
  logic [15:0]     s1_raw_q,   s1_raw_d;

  // S2 state
  logic              s2_valid_q, s2_valid_d;
  logic              s2_sign_q,  s2_sign_d;
  logic              s2_cast_q,  s2_cast_d;
  logic              s2_zero_q,  s2_zero_d;
  logic [FW-1:0]     s2_frac_q,  s2_frac_d;
  logic signed [7:0] s2_exp_q,   s2_exp_d;
  logic [15:0]       s2_raw_q,   s2_raw_d;

  // S3 state (drives the outputs directly)
  logic        s3_valid_q, s3_valid_d;
  logic [15:0] s3_fl16_q,  s3_fl16_d;
  logic        s3_ovf_q,   s3_ovf_d;
  logic        s3_unf_q,   s3_unf_d;

  // Whole pipeline moves together; it only freezes when the last stage holds
  // a result nobody is taking.
  assign advance  = ~s3_valid_q | out_ready;
  assign in_ready = advance;

  assign out_valid = s3_valid_q;
  assign out_fl16  = s3_fl16_q;
  assign out_ovf   = s3_ovf_q;
  assign out_unf   = s3_unf_q;

  // ---------------- S1: sign / magnitude ----------------
  // Negating the most negative value wraps to 2^(IN_W-1), which is exactly
  // the magnitude wanted when read as unsigned.
  always_comb begin
    s1_valid_d = in_valid;
    s1_sign_d  = in_signed & in_data[IN_W-1];
    s1_cast_d  = cast_;
    s1_mag_d   = s1_sign_d ? (~in_data + IN_W'(1)) : in_data;
    s1_raw_d   = 16'(in_data);
  end

  // ---------------- S2: leading one + normalise ----------------
  logic [5:0] lead_pos;

  always_comb begin
    lead_pos = '0;
    for (int i = 0; i < IN_W; i++) begin
      if (s1_mag_q[i]) lead_pos = 6'(i);
    end
  end

  always_comb begin
    s2_valid_d = s1_valid_q;
    s2_sign_d  = s1_sign_q;
    s2_cast_d  = s1_cast_q;
    s2_raw_d   = s1_raw_q;
    s2_zero_d  = (s1_mag_q == '0);
    // Shift the leading one up to bit IN_W-1, then keep only the bits below it.
    s2_frac_d  = FW'(s1_mag_q << (6'(IN_W - 1) - lead_pos));
    s2_exp_d   = 8'(int'(lead_pos) - FRAC_W + 15);
  end

  // ---------------- S3: round, adjust, pack ----------------
  logic [XW-1:0]     ext;
  logic [9:0]        mant;
  logic              guard;
  logic              sticky;
  logic              round_up;
  logic [10:0]       mant_sum;
  logic signed [7:0] exp_r;

  always_comb begin
    ext      = {s2_frac_q, 11'b0};
    mant     = ext[XW-1 -: 10];
    guard    = ext[XW-11];
    sticky   = |ext[XW-12:0];
    round_up = guard & (sticky | mant[0]);
    mant_sum = {1'b0, mant} + 11'(round_up);
    // A carry out of the mantissa leaves mant_sum[9:0] at zero, which is the
    // correct mantissa for the bumped exponent.
    exp_r    = s2_exp_q + 8'(mant_sum[10]);
  end

  always_comb begin
    s3_valid_d = s2_valid_q;
    s3_fl16_d  = 16'h0000;
    s3_ovf_d   = 1'b0;
    s3_unf_d   = 1'b0;
    if (s2_valid_q) begin
      if (!s2_cast_q) begin
        s3_fl16_d = s2_raw_q;
      end else if (!s2_zero_q) begin
        if (exp_r > 8'sd30) begin
          s3_fl16_d = {s2_sign_q, 5'h1F, 10'h000};
          s3_ovf_d  = 1'b1;
        end else if (exp_r < 8'sd1) begin
          s3_fl16_d = {s2_sign_q, 15'h0000};
          s3_unf_d  = 1'b1;
        end else begin
          s3_fl16_d = {s2_sign_q, exp_r[4:0], mant_sum[9:0]};
        end
      end
    end
  end

  // ---------------- registers ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_cast_q  <= 1'b0;
      s1_mag_q   <= '0;
      s1_raw_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_sign_q  <= 1'b0;
      s2_cast_q  <= 1'b0;
      s2_zero_q  <= 1'b1;
      s2_frac_q  <= '0;
      s2_exp_q   <= '0;
      s2_raw_q   <= '0;
      s3_valid_q <= 1'b0;
      s3_fl16_q  <= '0;
      s3_ovf_q   <= 1'b0;
      s3_unf_q   <= 1'b0;
    end else if (advance) begin
      s1_valid_q <= s1_valid_d;
      s1_sign_q  <= s1_sign_d;
      s1_cast_q  <= s1_cast_d;
      s1_mag_q   <= s1_mag_d;
      s1_raw_q   <= s1_raw_d;
      s2_valid_q <= s2_valid_d;
      s2_sign_q  <= s2_sign_d;
      s2_cast_q  <= s2_cast_d;
      s2_zero_q  <= s2_zero_d;
      s2_frac_q  <= s2_frac_d;
      s2_exp_q   <= s2_exp_d;
      s2_raw_q   <= s2_raw_d;
      s3_valid_q <= s3_valid_d;
      s3_fl16_q  <= s3_fl16_d;
      s3_ovf_q   <= s3_ovf_d;
      s3_unf_q   <= s3_unf_d;
    end
  end

endmodule

// File: tb/tb_fixed2float16_stream.sv
// Testbench for fixed2float16_stream. Three instances (FRAC_W = 0, 8, 15)
// share one input stream and one out_ready; a scoreboard built from an
// arithmetic reference model checks every output transfer of each instance.
module tb_fixed2float16_stream;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_signed;
  logic        cast_;
  logic        out_ready;

  logic        rdy0, rdy8, rdy15;
  logic        o0_v, o8_v, o15_v;
  logic [15:0] o0_f, o8_f, o15_f;
  logic        o0_ovf, o8_ovf, o15_ovf;
  logic        o0_unf, o8_unf, o15_unf;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fixed2float16_stream #(.IN_W(16), .FRAC_W(0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy0),
    .in_data(in_data), .in_signed(in_signed), .cast_(cast_),
    .out_valid(o0_v), .out_ready(out_ready), .out_fl16(o0_f),
    .out_ovf(o0_ovf), .out_unf(o0_unf));

  fixed2float16_stream #(.IN_W(16), .FRAC_W(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy8),
    .in_data(in_data), .in_signed(in_signed), .cast_(cast_),
    .out_valid(o8_v), .out_ready(out_ready), .out_fl16(o8_f),
    .out_ovf(o8_ovf), .out_unf(o8_unf));

  fixed2float16_stream #(.IN_W(16), .FRAC_W(15)) dut15 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy15),
    .in_data(in_data), .in_signed(in_signed), .cast_(cast_),
    .out_valid(o15_v), .out_ready(out_ready), .out_fl16(o15_f),
    .out_ovf(o15_ovf), .out_unf(o15_unf));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: {ovf, unf, fl16}. Works on the real value mag * 2^-frac
  // with integer arithmetic: find the top bit, scale to an 11-bit significand,
  // round half-to-even on the discarded remainder.
  function automatic logic [17:0] model(input logic [15:0] d, input bit sgn,
                                        input bit cst, input int frac);
    longint mag, q, rem, half;
    int     p, e, sh;
    bit     neg;
    if (!cst) return {2'b00, d};
    neg = sgn && d[15];
    mag = neg ? (longint'(65536) - longint'(d)) : longint'(d);
    if (mag == 0) return 18'h0;
    p = 0;
    while ((mag >> (p + 1)) != 0) p++;
    if (p <= 10) begin
      q = mag << (10 - p);
    end else begin
      sh   = p - 10;
      q    = mag >> sh;
      rem  = mag - (q << sh);
      half = longint'(1) << (sh - 1);
      if (rem > half || (rem == half && q[0])) q++;
      if (q == 2048) begin
        q = 1024;
        p++;
      end
    end
    e = p - frac + 15;
    if (e > 30) return {2'b10, neg, 5'h1F, 10'h000};
    if (e < 1)  return {2'b01, neg, 15'h0000};
    return {2'b00, neg, 5'(e), 10'(q)};
  endfunction

  // ---------------- scoreboard / protocol monitor ----------------
  logic [17:0] q0[$], q8[$], q15[$];
  logic        stall_prev = 1'b0;
  logic [18:0] prev_out;
  int          n_out = 0;

  always @(negedge clk) begin
    if (reset) begin
      q0.delete(); q8.delete(); q15.delete();
      stall_prev = 1'b0;
    end else begin
      check("ready_term", rdy0, !o0_v || out_ready);
      check("ready_lock", {rdy8, rdy15, o8_v, o15_v}, {rdy0, rdy0, o0_v, o0_v});
      if (!o0_v) check("idle_flags", {o0_ovf, o0_unf}, 0);
      if (stall_prev) check("stall_hold", {o0_v, o0_ovf, o0_unf, o0_f}, prev_out);
      if (o0_v && out_ready) begin
        n_out++;
        if (q0.size() == 0 || q8.size() == 0 || q15.size() == 0) begin
          check("sb_extra", 1, 0);
        end else begin
          check("sb_f0",  {o0_ovf, o0_unf, o0_f},    q0.pop_front());
          check("sb_f8",  {o8_ovf, o8_unf, o8_f},    q8.pop_front());
          check("sb_f15", {o15_ovf, o15_unf, o15_f}, q15.pop_front());
        end
      end
      if (in_valid && rdy0) begin
        q0.push_back(model(in_data, in_signed, cast_, 0));
        q8.push_back(model(in_data, in_signed, cast_, 8));
        q15.push_back(model(in_data, in_signed, cast_, 15));
      end
      stall_prev = o0_v && !out_ready;
      prev_out   = {o0_v, o0_ovf, o0_unf, o0_f};
    end
  end

  // ---------------- directed rows with exact-latency checks ----------------
  typedef struct {
    logic [15:0] d;
    bit          s;
    bit          c;
    logic [17:0] e0;
    bit          h8;
    logic [17:0] e8;
    bit          h15;
    logic [17:0] e15;
  } row_t;
  row_t rows[$];

  task automatic add_row(input logic [15:0] d, input bit s, input bit c, input logic [17:0] e0,
                         input bit h8, input logic [17:0] e8, input bit h15, input logic [17:0] e15);
    row_t r;
    r.d = d; r.s = s; r.c = c; r.e0 = e0; r.h8 = h8; r.e8 = e8; r.h15 = h15; r.e15 = e15;
    rows.push_back(r);
  endtask

  // Entered just after a rising edge with an empty pipeline and out_ready=1.
  // Beat k is offered in cycle k and must appear in cycle k+3.
  task automatic run_rows();
    int n;
    n = rows.size();
    for (int k = 0; k < n + 3; k++) begin
      if (k < n) begin
        in_valid  = 1'b1;
        in_data   = rows[k].d;
        in_signed = rows[k].s;
        cast_     = rows[k].c;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (k >= 3) begin
        check("lat_valid", o0_v, 1);
        check("dir_f0", {o0_ovf, o0_unf, o0_f}, rows[k-3].e0);
        if (rows[k-3].h8)  check("dir_f8",  {o8_ovf, o8_unf, o8_f},    rows[k-3].e8);
        if (rows[k-3].h15) check("dir_f15", {o15_ovf, o15_unf, o15_f}, rows[k-3].e15);
      end else begin
        check("lat_empty", o0_v, 0);
      end
      @(posedge clk); #1;
    end
    rows.delete();
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int t = 0; t < 50 && q0.size() != 0; t++) @(negedge clk);
    check("drain_empty", q0.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int idx;
    logic [15:0] bp_data[8];

    // Reset phase: beats offered now must not be captured.
    reset = 1'b1; in_valid = 1'b1; in_data = 16'h1234; in_signed = 1'b0;
    cast_ = 1'b1; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("rst_ready", rdy0, 1);
    check("rst_out", {o0_v, o0_ovf, o0_unf, o0_f}, 0);
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("post_rst_empty", {o0_v, o0_f}, 0);
    @(posedge clk); #1;

    // Directed values and exact latency.
    add_row(16'h0001, 0, 1, 18'h0_3C00, 0, 0, 0, 0);
    add_row(16'hFFE0, 0, 1, 18'h0_7BFF, 0, 0, 0, 0);
    add_row(16'hFFFF, 0, 1, 18'h2_7C00, 0, 0, 0, 0);
    add_row(16'hFFFF, 1, 1, 18'h0_BC00, 0, 0, 0, 0);
    add_row(16'h8000, 1, 1, 18'h0_F800, 0, 0, 0, 0);
    add_row(16'h0000, 1, 1, 18'h0_0000, 0, 0, 0, 0);
    add_row(16'd2049, 0, 1, 18'h0_6800, 0, 0, 0, 0);
    add_row(16'd2051, 0, 1, 18'h0_6802, 0, 0, 0, 0);
    add_row(16'h4248, 0, 0, 18'h0_4248, 1, 18'h0_4248, 1, 18'h0_4248);
    add_row(16'h0003, 0, 1, 18'h0_4200, 0, 0, 0, 0);
    add_row(16'h0180, 1, 1, 18'h0_5E00, 1, 18'h0_3E00, 0, 0);
    add_row(16'h0001, 0, 1, 18'h0_3C00, 0, 0, 1, 18'h1_0000);
    add_row(16'h0002, 0, 1, 18'h0_4000, 0, 0, 1, 18'h0_0400);
    run_rows();

    // Backpressure: 8 beats, out_ready low for 4 cycles mid-stream.
    idx = 0;
    for (int i = 0; i < 8; i++) bp_data[i] = 16'(100 + i * 777);
    for (int cyc = 0; cyc < 30 && idx < 8; cyc++) begin
      out_ready = !(cyc >= 4 && cyc < 8);
      in_valid  = 1'b1;
      in_data   = bp_data[idx];
      in_signed = idx[0];
      cast_     = (idx != 5);
      @(negedge clk);
      if (cyc >= 4 && cyc < 8 && o0_v) check("bp_ready_low", rdy0, 0);
      if (in_valid && rdy0) idx++;
      @(posedge clk); #1;
    end
    check("bp_all_sent", idx, 8);
    drain();

    // Randomized traffic.
    for (int cyc = 0; cyc < 800; cyc++) begin
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(3) != 0);
      in_signed = $urandom_range(1);
      cast_     = ($urandom_range(7) != 0);
      case ($urandom_range(7))
        0:       in_data = 16'h0000;
        1:       in_data = 16'h8000;
        2:       in_data = 16'hFFFF;
        3:       in_data = 16'($urandom_range(15));
        4:       in_data = 16'hFFE0 + 16'($urandom_range(31));
        5:       in_data = 16'h0800 + 16'($urandom_range(7));
        default: in_data = 16'($urandom);
      endcase
      @(posedge clk); #1;
    end
    drain();

    // Reset with three beats in flight.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 16'(7 + i); in_signed = 1'b0; cast_ = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b1; in_data = 16'h0055;
    #1 reset = 1'b1;
    #1;
    check("rst_now_out", {o0_v, o0_ovf, o0_unf, o0_f}, 0);
    check("rst_now_ready", rdy0, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rst_no_ghost", o0_v, 0);
    end
    @(posedge clk); #1;

    // First beats after release.
    add_row(16'h0005, 0, 1, 18'h0_4500, 0, 0, 0, 0);
    add_row(16'hFFFE, 1, 1, 18'h0_C000, 0, 0, 0, 0);
    run_rows();
    drain();

    check("outputs_seen", (n_out > 100), 1);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
